// File: rtl/wb_timer.sv
// wb_timer: Wishbone-attached 64-bit machine timer with a compare interrupt.
//
// Ports
//   wb_clk_i     system clock; all state updates on its rising edge
//   wb_rst_i     synchronous, active-high reset
//   wb_adr_i     byte address; only [4:2] selects a register
//   wb_dat_i     write data
//   wb_sel_i     byte-lane enables for writes
//   wb_we_i      1 = write, 0 = read
//   wb_cyc_i     bus cycle active
//   wb_stb_i     strobe: request present
//   wb_dat_o     read data, registered, valid while wb_ack_o = 1
//   wb_ack_o     single-cycle acknowledge
//   wb_err_o     constant 0
//   timer_irq_o  level interrupt = irq_en & (mtime >= mtimecmp), one cycle late
//
// Register map (word offset wb_adr_i[4:2]):
//   0 MTIME_LO  1 MTIME_HI (reads return hi_shadow)  2 MTIMECMP_LO
//   3 MTIMECMP_HI  4 CTRL {irq_en, count_en}  5 PRESCALE  6 STATUS  7 reserved
//
// Handshake: a request is accepted on any rising edge where
// wb_cyc_i & wb_stb_i & ~wb_ack_o. Writes and read-data capture happen on that
// edge and wb_ack_o is high for exactly the following cycle. Because an ack
// blocks acceptance, a held strobe completes at most once every two cycles.
// Reset drops any request in flight: no ack and no write.

module wb_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        timer_irq_o
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  count_en;
  logic                  irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           hi_shadow;

  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic [2:0]            off;
  logic                  tick;
  logic                  cmp_ge;
  logic [31:0]           rd_data;
  logic [PRESCALE_W-1:0] prescale_wr;

  // Address bits outside [4:2] are intentionally ignored.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en  = accept & wb_we_i;
  assign rd_en  = accept & ~wb_we_i;
  assign off    = wb_adr_i[4:2];
  assign tick   = count_en & (pcnt == prescale);
  assign cmp_ge = (mtime >= mtimecmp);
  assign wb_err_o = 1'b0;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // PRESCALE is narrower than the bus; merge bit by bit using the owning lane.
  always_comb begin
    prescale_wr = prescale;
    for (int i = 0; i < PRESCALE_W; i++) begin
      if (wb_sel_i[i/8]) prescale_wr[i] = wb_dat_i[i];
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (off)
      OFF_MTIME_LO: rd_data = mtime[31:0];
      OFF_MTIME_HI: rd_data = hi_shadow;
      OFF_CMP_LO:   rd_data = mtimecmp[31:0];
      OFF_CMP_HI:   rd_data = mtimecmp[63:32];
      OFF_CTRL:     rd_data = {30'd0, irq_en, count_en};
      OFF_PRESCALE: rd_data = 32'(prescale);
      OFF_STATUS:   rd_data = {31'd0, cmp_ge};
      default:      rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime       <= 64'd0;
      mtimecmp    <= '1;
      count_en    <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      pcnt        <= '0;
      hi_shadow   <= 32'd0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 32'd0;
      timer_irq_o <= 1'b0;
    end else begin
      wb_ack_o    <= accept;
      timer_irq_o <= irq_en & cmp_ge;

      if (rd_en) begin
        wb_dat_o <= rd_data;
        // Snapshot HI with LO so a LO-then-HI read pair is coherent.
        if (off == OFF_MTIME_LO) hi_shadow <= mtime[63:32];
      end

      // A bus write to either mtime half suppresses the tick for that cycle.
      if (wr_en && off == OFF_MTIME_LO) begin
        mtime[31:0] <= merge_lanes(mtime[31:0], wb_dat_i, wb_sel_i);
      end else if (wr_en && off == OFF_MTIME_HI) begin
        mtime[63:32] <= merge_lanes(mtime[63:32], wb_dat_i, wb_sel_i);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_en && off == OFF_CMP_LO) begin
        mtimecmp[31:0] <= merge_lanes(mtimecmp[31:0], wb_dat_i, wb_sel_i);
      end
      if (wr_en && off == OFF_CMP_HI) begin
        mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], wb_dat_i, wb_sel_i);
      end
      if (wr_en && off == OFF_CTRL && wb_sel_i[0]) begin
        count_en <= wb_dat_i[0];
        irq_en   <= wb_dat_i[1];
      end
      if (wr_en && off == OFF_PRESCALE) begin
        prescale <= prescale_wr;
      end

      // Reconfiguring the timer restarts the prescale period.
      if (wr_en && (off == OFF_CTRL || off == OFF_PRESCALE)) begin
        pcnt <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else if (count_en) begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16: width of the PRESCALE register and the prescale counter.
REQ-002 SHALL have port wb_clk_i  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports wb_adr_i in 32 (byte address; only [4:2] decoded), wb_dat_i in 32, wb_sel_i in 4, wb_we_i in 1, wb_cyc_i in 1, wb_stb_i in 1: Wishbone slave request from the interconnect.
REQ-005 SHALL have ports wb_dat_o out 32, wb_ack_o out 1, wb_err_o out 1: Wishbone slave response.
REQ-006 SHALL have port timer_irq_o  out  1  machine timer interrupt, level, registered.

Function
REQ-007 SHALL implement this register map at word offset wb_adr_i[4:2]:
- 0 MTIME_LO (RW)
- 1 MTIME_HI (RW; reads return hi_shadow)
- 2 MTIMECMP_LO (RW)
- 3 MTIMECMP_HI (RW)
- 4 CTRL (RW): [0] count_en, [1] irq_en; other bits read 0
- 5 PRESCALE (RW, PRESCALE_W bits, upper bits read 0)
- 6 STATUS (RO): [0] = (mtime >= mtimecmp)
- 7 reserved: reads 0, writes ignored.
REQ-008 SHALL accept a request in any cycle with wb_cyc_i & wb_stb_i & ~wb_ack_o, and assert wb_ack_o for exactly one cycle in the following cycle.
REQ-009 SHALL deassert wb_ack_o the cycle after any ack, so back-to-back requests complete at most every 2 cycles.
REQ-010 SHALL register read data into wb_dat_o in the accept cycle, so it is valid while wb_ack_o=1; wb_dat_o SHALL hold its value otherwise.
REQ-011 SHALL perform writes in the accept cycle, honouring wb_sel_i per byte lane; lanes with sel=0 are unchanged.
REQ-012 SHALL tie wb_err_o to 0.
REQ-013 SHALL, on a read of MTIME_LO, load hi_shadow with mtime[63:32] as of the same cycle, giving a consistent 64-bit LO-then-HI read.
REQ-014 SHALL keep a prescale counter while count_en=1: tick when counter==PRESCALE, then reset the counter to 0; otherwise increment it.
- PRESCALE=0 ticks every cycle.
REQ-015 SHALL increment 64-bit mtime by 1 on each tick, carrying LO into HI, and wrap from 0xFFFFFFFF_FFFFFFFF to 0.
REQ-016 SHALL hold the prescale counter and mtime while count_en=0.
REQ-017 SHALL give a bus write to MTIME_LO/HI priority over a tick in the same cycle: written lanes take the bus value, unwritten lanes keep the pre-increment value, and no increment occurs that cycle.
REQ-018 SHALL clear the prescale counter to 0 on any write to PRESCALE or to CTRL.
REQ-019 SHALL compare mtime >= mtimecmp as unsigned 64-bit values each cycle.
REQ-020 SHALL set timer_irq_o in the next cycle to irq_en & (mtime >= mtimecmp), i.e. one cycle of latency after the comparison condition changes.
REQ-021 SHALL drive timer_irq_o level-sensitive: it clears only by raising mtimecmp, writing mtime lower, or clearing irq_en; there is no write-to-clear.

Reset
REQ-022 SHALL, while wb_rst_i=1 at a clock edge, set:
- mtime=0, mtimecmp=0xFFFFFFFF_FFFFFFFF, CTRL=0, PRESCALE=0
- prescale counter=0, hi_shadow=0
- wb_ack_o=0, wb_dat_o=0, timer_irq_o=0
REQ-023 SHALL abandon any in-flight request when reset is asserted mid-transaction: no ack is issued, and the write does not take effect if reset is in the same cycle.

Verification
REQ-024 Reset, then read offsets 0..7 -> 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0, 0, 0; each ack is a single cycle, one cycle after stb.
REQ-025 PRESCALE=3, CTRL=1, run 40 cycles from the CTRL write -> mtime=10 (one tick per 4 cycles); then CTRL=0 -> mtime frozen.
REQ-026 Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0, count_en=1, PRESCALE=0 -> next tick gives HI=1, LO=0. Write both to 0xFFFFFFFF -> wraps to 0.
REQ-027 mtimecmp=20, CTRL=3, PRESCALE=0, mtime=0 -> timer_irq_o rises exactly 1 cycle after mtime reaches 20. Write MTIMECMP_HI=1 -> irq falls 1 cycle later. Write CTRL=1 with condition true -> irq stays 0.
REQ-028 Byte write: MTIMECMP_LO with sel=4'b0010, data 0x0000AB00 onto 0x11223344 -> reads 0x1122AB44. Tick coincident with an MTIME_LO write -> written value with no increment.
REQ-029 Read MTIME_LO, let mtime[63:32] change, then read MTIME_HI -> returns the pre-change HI value. Assert reset between stb and ack -> no ack is issued and all registers return to reset values.
